// File: rtl/grn_attractor_ctrl.sv
// Attractor search controller: sweeps a range of initial states over a Boolean network.
// It runs a slow and a fast copy until they meet on an even step count, or until MAX_STEPS.
module grn_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] cfg_first,
  input  logic [N_NODES-1:0] cfg_last,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] nodes_s0,
  input  logic [N_NODES-1:0] nodes_s1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [N_NODES-1:0] res_state,
  output logic [CNT_W-1:0]   res_steps,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_REPORT = 3'd3,
    S_NEXT   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0]   TWO_C  = CNT_W'(2);
  localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   ZERO_C = {CNT_W{1'b0}};
  localparam logic [N_NODES-1:0] NODE_ONE  = N_NODES'(1);
  localparam logic [N_NODES-1:0] NODE_ZERO = {N_NODES{1'b0}};

  state_e             state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d;
  logic [N_NODES-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reset_nos_q, reset_nos_d;
  logic [N_NODES-1:0] init_q, init_d;
  logic               res_valid_q, res_valid_d;
  logic [N_NODES-1:0] res_init_q, res_init_d;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [CNT_W-1:0]   res_steps_q, res_steps_d;
  logic               res_timeout_q, res_timeout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               meet_s, at_max_s, step_s;

  // The slow copy advances every second pulse, so a meeting is only meaningful on even counts.
  assign meet_s   = (nodes_s0 == nodes_s1) && !cnt_q[0] && (cnt_q >= TWO_C);
  assign at_max_s = (cnt_q >= MAX_C);
  assign step_s   = (state_q == S_RUN) && !meet_s && !at_max_s;

  assign start_s0    = step_s;
  assign start_s1    = step_s;
  assign reset_nos   = reset_nos_q;
  assign init_state  = init_q;
  assign res_valid   = res_valid_q;
  assign res_init    = res_init_q;
  assign res_state   = res_state_q;
  assign res_steps   = res_steps_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Next-state, sweep bookkeeping and next output values.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    res_init_d    = res_init_q;
    res_state_d   = res_state_q;
    res_steps_d   = res_steps_q;
    res_timeout_d = res_timeout_q;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_first > cfg_last) begin
            done_d = 1'b1;
          end else begin
            cur_d   = cfg_first;
            last_d  = cfg_last;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = ZERO_C;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (meet_s || at_max_s) begin
          res_init_d    = cur_q;
          res_state_d   = nodes_s1;
          res_steps_d   = meet_s ? cnt_q : MAX_C;
          res_timeout_d = !meet_s;
          state_d       = S_REPORT;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_REPORT;
        end
      end
      S_NEXT: begin
        if (cur_q == last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cur_d   = cur_q + NODE_ONE;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    reset_nos_d = (state_d == S_LOAD);
    init_d      = (state_d == S_LOAD) ? cur_d : NODE_ZERO;
    res_valid_d = (state_d == S_REPORT);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_q         <= NODE_ZERO;
      last_q        <= NODE_ZERO;
      cnt_q         <= ZERO_C;
      reset_nos_q   <= 1'b0;
      init_q        <= NODE_ZERO;
      res_valid_q   <= 1'b0;
      res_init_q    <= NODE_ZERO;
      res_state_q   <= NODE_ZERO;
      res_steps_q   <= ZERO_C;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      reset_nos_q   <= reset_nos_d;
      init_q        <= init_d;
      res_valid_q   <= res_valid_d;
      res_init_q    <= res_init_d;
      res_state_q   <= res_state_d;
      res_steps_q   <= res_steps_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: doc/grn_attractor_ctrl.md
GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

Interface
REQ-001 SHALL have parameter N_NODES, default 8, number of Boolean network nodes driven and observed.
REQ-002 SHALL have parameter CNT_W, default 16, width of the step counter and the step result.
REQ-003 SHALL have parameter MAX_STEPS, default 1000, step limit per initial state before timeout.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begin sweep, sampled only in IDLE.
REQ-007 SHALL have ports cfg_first, cfg_last  input  N_NODES  inclusive initial-state sweep range, sampled with start.
REQ-008 SHALL have port reset_nos  output  1  load pulse to all nodes.
REQ-009 SHALL have port init_state  output  N_NODES  bit i is the load value for node i.
REQ-010 SHALL have ports start_s0, start_s1  output  1  step enables for the slow (s0) and fast (s1) node copies.
REQ-011 SHALL have ports nodes_s0, nodes_s1  input  N_NODES  concatenated registered node states, s0 and s1 copies.
REQ-012 SHALL have ports res_valid  output  1; res_ready  input  1  result handshake.
REQ-013 SHALL have ports res_init, res_state  output  N_NODES  initial state, and nodes_s1 at detection.
REQ-014 SHALL have ports res_steps  output  CNT_W; res_timeout  output  1.
REQ-015 SHALL have ports busy  output  1; done  output  1  one-cycle pulse at sweep end.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, REPORT, NEXT.
REQ-017 IDLE: start=1 SHALL latch cur=cfg_first and last=cfg_last and go to LOAD; if cfg_first>cfg_last SHALL instead pulse done next cycle and stay IDLE.
REQ-018 LOAD: reset_nos=1 and init_state=cur for exactly one cycle; step_cnt cleared to 0; next state RUN.
REQ-019 RUN: step_cnt counts start pulses already issued; meet SHALL be (nodes_s0==nodes_s1) AND step_cnt even AND step_cnt>=2.
REQ-020 RUN: start_s0=start_s1=1 when NOT meet and step_cnt<MAX_STEPS; step_cnt increments on each such cycle; both enables SHALL always be equal.
REQ-021 RUN: on meet, latch res_state=nodes_s1, res_steps=step_cnt, res_timeout=0, go to REPORT; no start pulse that cycle.
REQ-022 RUN: if NOT meet and step_cnt==MAX_STEPS, latch res_state=nodes_s1, res_steps=MAX_STEPS, res_timeout=1, go to REPORT; meet takes priority on the same cycle.
REQ-023 REPORT: res_valid=1 with res_init=cur; outputs SHALL hold stable until res_ready=1; transfer on valid&&ready, then NEXT.
REQ-024 NEXT: if cur==last, pulse done, go IDLE; else cur=cur+1 (no wrap past last, including last=all-ones), go LOAD.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-026 reset_nos, start_s0, start_s1 SHALL never be asserted together.
REQ-027 step_cnt SHALL saturate at MAX_STEPS; MAX_STEPS SHALL fit in CNT_W.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, all outputs 0 (res_* fields, res_valid, busy, done, reset_nos, start_s0, start_s1, init_state), counters 0.
REQ-029 rst asserted mid-RUN or mid-REPORT SHALL abandon the sweep with no further result or done pulse.

Verification
REQ-030 Identity network (N=4), range 3..3: reset_nos with init_state=4'h3, two step pulses, result init=3, steps=2, state=3, timeout=0, then done.
REQ-031 Negation network (N=4), range 5..5: result steps=4, state=4'h5, timeout=0.
REQ-032 Negation network, MAX_STEPS=3: result steps=3, timeout=1, exactly 3 step pulses issued.
REQ-033 Identity network, range 14..15, res_ready held low 5 cycles on first result: res fields stable, second LOAD only after handshake, two results then done.
REQ-034 cfg_first=9, cfg_last=2: no reset_nos, no result, done one cycle after start.
REQ-035 rst pulsed during RUN at step 3: all outputs 0 same cycle, no result, start ignored until rst low.
